fsm_cmd_arbiter: RTL and testbench

- Round-robin arbiter that shares the 2-bit command input of one state-machine datapath between NUM_REQ requesters.
- Grants one requester at a time, forwards that requester's command, and limits each tenure to MAX_HOLD cycles.
- Inserts one idle cooldown cycle between tenures so the downstream FSM always sees a quiet command cycle at each ownership change.
- Sits between requester logic and the shared FSM's command input.

---
 rtl/fsm_arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 27 ++
 rtl/fsm_cmd_arbiter.sv | 119 +++++++++++
 tb/tb_fsm_cmd_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fsm_arb_pkg.sv
// Shared types and defaults for the command arbiter family.
// Holds the arbiter state encoding and the round-robin index helper.
package fsm_arb_pkg;

   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_CMD_WIDTH = 2;
   localparam int DEF_MAX_HOLD  = 4;

   typedef enum logic [1:0] {
      Idle     = 2'd0,
      Grant    = 2'd1,
      Cooldown = 2'd2
   } arb_state_t;

   // Index reached by stepping 'off' places from 'base' around a ring of n slots.
   function automatic int wrap_idx(input int base, input int off, input int n);
      int s;
      s = base + off;
      return (s >= n) ? (s - n) : s;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request found scanning from i_ptr upward, wrapping.
// o_any_req is low and o_pick is zero when no request is set.
module rr_pick
   import fsm_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [PTR_W-1:0]   o_pick,
   output logic               o_any_req
);

   // Scan from the far end so the candidate closest to i_ptr is written last and wins.
   always_comb begin
      o_pick    = '0;
      o_any_req = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (i_req[wrap_idx(int'(i_ptr), k, NUM_REQ)]) begin
            o_pick    = PTR_W'(wrap_idx(int'(i_ptr), k, NUM_REQ));
            o_any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fsm_cmd_arbiter.sv
// Round-robin arbiter sharing one FSM command input between NUM_REQ requesters.
// Tenures are capped at MAX_HOLD cycles and every tenure is followed by one quiet cooldown cycle.
module fsm_cmd_arbiter
   import fsm_arb_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int CMD_WIDTH = DEF_CMD_WIDTH,
   parameter int MAX_HOLD  = DEF_MAX_HOLD
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*CMD_WIDTH-1:0]  cmd_in,
   output logic [NUM_REQ-1:0]            grant,
   output logic [CMD_WIDTH-1:0]          cmd_out,
   output logic                          cmd_valid,
   output logic                          busy
);

   localparam int PTR_W  = $clog2(NUM_REQ);
   localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

   arb_state_t           r_state;
   logic [PTR_W-1:0]     r_winner;
   logic [PTR_W-1:0]     r_ptr;
   logic [HOLD_W-1:0]    r_hold_cnt;
   logic [NUM_REQ-1:0]   r_grant;
   logic                 r_cmd_valid;
   logic                 r_busy;

   logic [PTR_W-1:0]     w_pick;
   logic                 w_any_req;
   logic [PTR_W-1:0]     w_ptr_next;
   logic [NUM_REQ-1:0]   w_pick_onehot;
   logic                 w_hold_last;
   logic                 w_exit;
   logic [CMD_WIDTH-1:0] w_cmd_out;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_pick (
      .i_req     (req),
      .i_ptr     (r_ptr),
      .o_pick    (w_pick),
      .o_any_req (w_any_req)
   );

   // The pointer moves just past the new winner, making it lowest priority next round.
   assign w_ptr_next    = (w_pick == PTR_W'(NUM_REQ - 1)) ? '0 : (w_pick + 1'b1);
   assign w_pick_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
   assign w_hold_last   = (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));
   assign w_exit        = !req[r_winner] || w_hold_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= Idle;
         r_winner    <= '0;
         r_ptr       <= '0;
         r_hold_cnt  <= '0;
         r_grant     <= '0;
         r_cmd_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            Idle: begin
               if (w_any_req) begin
                  r_state     <= Grant;
                  r_winner    <= w_pick;
                  r_ptr       <= w_ptr_next;
                  r_hold_cnt  <= '0;
                  r_grant     <= w_pick_onehot;
                  r_cmd_valid <= 1'b1;
                  r_busy      <= 1'b1;
               end else begin
                  r_grant     <= '0;
                  r_cmd_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end
            end
            Grant: begin
               r_hold_cnt <= r_hold_cnt + 1'b1;
               if (w_exit) begin
                  r_state     <= Cooldown;
                  r_grant     <= '0;
                  r_cmd_valid <= 1'b0;
                  r_busy      <= 1'b1;
               end
            end
            Cooldown: begin
               r_state     <= Idle;
               r_grant     <= '0;
               r_cmd_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
            default: begin
               r_state     <= Idle;
               r_grant     <= '0;
               r_cmd_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   // cmd_valid has no ready partner: the shared FSM must consume cmd_out in every cycle it is high.
   always_comb begin
      w_cmd_out = '0;
      if (r_state == Grant) begin
         w_cmd_out = cmd_in[r_winner*CMD_WIDTH +: CMD_WIDTH];
      end
   end

   assign grant     = r_grant;
   assign cmd_valid = r_cmd_valid;
   assign busy      = r_busy;
   assign cmd_out   = w_cmd_out;

endmodule

// File: tb/tb_fsm_cmd_arbiter.sv
// Directed bench for fsm_cmd_arbiter: a per-cycle vector table followed by hand-written
// sequences for latency, live command forwarding, drop-with-pending, tenure length and gap.
module tb_fsm_cmd_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [7:0] cmd_in;
   logic [3:0] grant;
   logic [1:0] cmd_out;
   logic       cmd_valid;
   logic       busy;

   int   n_cmp = 0;
   int   n_bad = 0;
   logic mon_en = 1'b0;
   int   lat;
   int   cnt;
   int   gap;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] grant;
      logic [1:0] cmd;
      logic       valid;
      logic       busy;
   } vec_t;

   vec_t tbl[$];

   fsm_cmd_arbiter #(
      .NUM_REQ   (4),
      .CMD_WIDTH (2),
      .MAX_HOLD  (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .cmd_in    (cmd_in),
      .grant     (grant),
      .cmd_out   (cmd_out),
      .cmd_valid (cmd_valid),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic addn(input int n, input logic r, input logic [3:0] q, input logic [3:0] g,
                       input logic [1:0] c, input logic v, input logic b);
      vec_t e;
      e.rst = r; e.req = q; e.grant = g; e.cmd = c; e.valid = v; e.busy = b;
      repeat (n) tbl.push_back(e);
   endtask

   // Structural invariants checked every cycle once out of reset.
   always @(negedge clk) begin
      if (mon_en) begin
         check("grant_onehot0", {31'b0, $onehot0(grant)}, 32'd1);
         check("valid_vs_grant", {31'b0, cmd_valid}, {31'b0, |grant});
      end
   end

   initial begin
      rst    = 1'b1;
      req    = 4'b0000;
      cmd_in = 8'h36;   // req0->2, req1->1, req2->3, req3->0
      repeat (2) @(posedge clk);
      @(negedge clk);
      mon_en = 1'b1;

      // Each row: inputs for this cycle, then outputs expected during this cycle.
      // Quiet after reset
      addn(10, 0, 4'b0000, 4'b0000, 2'd0, 0, 0);
      // Single requester 1 held: 4-cycle tenure, cooldown, idle, regrant, then drop
      addn(1, 0, 4'b0010, 4'b0000, 2'd0, 0, 0);
      addn(4, 0, 4'b0010, 4'b0010, 2'd1, 1, 1);
      addn(1, 0, 4'b0010, 4'b0000, 2'd0, 0, 1);
      addn(1, 0, 4'b0010, 4'b0000, 2'd0, 0, 0);
      addn(1, 0, 4'b0000, 4'b0010, 2'd1, 1, 1);
      addn(1, 0, 4'b0000, 4'b0000, 2'd0, 0, 1);
      addn(1, 0, 4'b0000, 4'b0000, 2'd0, 0, 0);
      // Reset from idle returns ptr to 0
      addn(1, 1, 4'b0000, 4'b0000, 2'd0, 0, 0);
      // All four requesting: rotate 0,1,2,3,0
      addn(1, 0, 4'b1111, 4'b0000, 2'd0, 0, 0);
      addn(4, 0, 4'b1111, 4'b0001, 2'd2, 1, 1);
      addn(1, 0, 4'b1111, 4'b0000, 2'd0, 0, 1);
      addn(1, 0, 4'b1111, 4'b0000, 2'd0, 0, 0);
      addn(4, 0, 4'b1111, 4'b0010, 2'd1, 1, 1);
      addn(1, 0, 4'b1111, 4'b0000, 2'd0, 0, 1);
      addn(1, 0, 4'b1111, 4'b0000, 2'd0, 0, 0);
      addn(4, 0, 4'b1111, 4'b0100, 2'd3, 1, 1);
      addn(1, 0, 4'b1111, 4'b0000, 2'd0, 0, 1);
      addn(1, 0, 4'b1111, 4'b0000, 2'd0, 0, 0);
      addn(4, 0, 4'b1111, 4'b1000, 2'd0, 1, 1);
      addn(1, 0, 4'b1111, 4'b0000, 2'd0, 0, 1);
      addn(1, 0, 4'b1111, 4'b0000, 2'd0, 0, 0);
      addn(4, 0, 4'b1111, 4'b0001, 2'd2, 1, 1);
      addn(1, 0, 4'b0000, 4'b0000, 2'd0, 0, 1);
      addn(1, 0, 4'b0000, 4'b0000, 2'd0, 0, 0);
      // ptr=1, req 1001: winner 3, then pointer wraps so 0 wins over 3
      addn(1, 0, 4'b1001, 4'b0000, 2'd0, 0, 0);
      addn(4, 0, 4'b1001, 4'b1000, 2'd0, 1, 1);
      addn(1, 0, 4'b1001, 4'b0000, 2'd0, 0, 1);
      addn(1, 0, 4'b1001, 4'b0000, 2'd0, 0, 0);
      addn(1, 0, 4'b0000, 4'b0001, 2'd2, 1, 1);
      addn(1, 0, 4'b0000, 4'b0000, 2'd0, 0, 1);
      addn(1, 0, 4'b0000, 4'b0000, 2'd0, 0, 0);
      // req0 pulse seen only in idle: 1-cycle grant, then cooldown
      addn(1, 0, 4'b0001, 4'b0000, 2'd0, 0, 0);
      addn(1, 0, 4'b0000, 4'b0001, 2'd2, 1, 1);
      addn(1, 0, 4'b0000, 4'b0000, 2'd0, 0, 1);
      addn(1, 0, 4'b0000, 4'b0000, 2'd0, 0, 0);
      // Reset on 2nd grant cycle of requester 2: no cooldown, ptr back to 0
      addn(1, 0, 4'b0100, 4'b0000, 2'd0, 0, 0);
      addn(1, 0, 4'b0100, 4'b0100, 2'd3, 1, 1);
      addn(1, 1, 4'b0100, 4'b0100, 2'd3, 1, 1);
      addn(1, 0, 4'b1101, 4'b0000, 2'd0, 0, 0);
      addn(1, 0, 4'b0000, 4'b0001, 2'd2, 1, 1);
      addn(1, 0, 4'b0000, 4'b0000, 2'd0, 0, 1);
      addn(1, 0, 4'b0000, 4'b0000, 2'd0, 0, 0);

      foreach (tbl[i]) begin
         rst = tbl[i].rst;
         req = tbl[i].req;
         #1;
         check($sformatf("row%0d_grant", i), {28'b0, grant}, {28'b0, tbl[i].grant});
         check($sformatf("row%0d_cmd_out", i), {30'b0, cmd_out}, {30'b0, tbl[i].cmd});
         check($sformatf("row%0d_cmd_valid", i), {31'b0, cmd_valid}, {31'b0, tbl[i].valid});
         check($sformatf("row%0d_busy", i), {31'b0, busy}, {31'b0, tbl[i].busy});
         @(negedge clk);
      end

      // Idle with ptr=1: req 0110 grants requester 1 after one edge
      req = 4'b0110;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (grant == 4'b0000 && lat < 8);
      check("grant_latency", lat, 1);
      check("seq_grant_r1", {28'b0, grant}, 32'h2);

      // cmd_out follows cmd_in live during the tenure
      cmd_in = 8'h3A;   // req1 field becomes 2
      #1;
      check("cmd_live", {30'b0, cmd_out}, 32'd2);

      // Winner drops while requester 2 pends: cooldown still inserted
      req = 4'b0100;
      @(posedge clk); #1;
      check("drop_cd_grant", {28'b0, grant}, 32'h0);
      check("drop_cd_busy", {31'b0, busy}, 32'd1);
      check("drop_cd_valid", {31'b0, cmd_valid}, 32'd0);
      @(posedge clk); #1;
      check("drop_idle_grant", {28'b0, grant}, 32'h0);
      check("drop_idle_busy", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;
      check("drop_next_grant", {28'b0, grant}, 32'h4);
      check("drop_next_cmd", {30'b0, cmd_out}, 32'd3);

      // Held request: tenure capped at 4 cycles, then a 2-cycle gap before regrant
      cnt = 1;
      while (cnt < 10) begin
         @(posedge clk); #1;
         if (grant == 4'b0100) cnt++;
         else break;
      end
      check("tenure_len", cnt, 4);
      gap = 0;
      while (grant == 4'b0000 && gap < 10) begin
         gap++;
         @(posedge clk); #1;
      end
      check("regrant_gap", gap, 2);
      check("regrant_r2", {28'b0, grant}, 32'h4);

      req = 4'b0000;
      repeat (3) @(posedge clk);
      #1;
      check("drain_busy", {31'b0, busy}, 32'd0);
      check("drain_grant", {28'b0, grant}, 32'h0);

      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
